// File: rtl/timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_pkg                                                            |
// | Shared state encoding, BCD time record and the BCD one-second        |
// | decrement used by the microwave timer.                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package timer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        RUNNING = 3'd2,
        PAUSED  = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
    localparam logic [3:0] SEC_TENS_WRAP = 4'd5;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_units;
        logic [3:0] sec_tens;
        logic [3:0] sec_units;
    } bcd_time_t;

    localparam bcd_time_t TIME_ZERO = '0;

    // Seconds above 59 are decremented as entered; only 00 borrows a minute.
    function automatic bcd_time_t bcd_dec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t == TIME_ZERO) begin
            r = t;
        end else if (t.sec_units != 4'd0) begin
            r.sec_units = t.sec_units - 4'd1;
        end else begin
            r.sec_units = BCD_MAX_UNITS;
            if (t.sec_tens != 4'd0) begin
                r.sec_tens = t.sec_tens - 4'd1;
            end else begin
                r.sec_tens = SEC_TENS_WRAP;
                if (t.min_units != 4'd0) begin
                    r.min_units = t.min_units - 4'd1;
                end else begin
                    r.min_units = BCD_MAX_UNITS;
                    r.min_tens  = t.min_tens - 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pgt_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pgt_sync                                                             |
// | Synchronises pgt/D/loadn together and flags rising edges of pgt.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pgt_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pgt,
    input  logic [3:0] D,
    input  logic       loadn,
    output logic       evt,
    output logic [3:0] evt_d,
    output logic       evt_loadn
);

    // Each stage carries {pgt, loadn, D} so data stays aligned with the edge.
    logic [SYNC_STAGES-1:0][5:0] r_sync_q;
    logic [SYNC_STAGES-1:0][5:0] w_sync_d;
    logic                        r_pgt_prev_q;
    logic                        w_pgt_prev_d;

    always_comb begin
        w_sync_d     = {r_sync_q[SYNC_STAGES-2:0], pgt, loadn, D};
        w_pgt_prev_d = r_sync_q[SYNC_STAGES-1][5];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_q     <= '0;
            r_pgt_prev_q <= 1'b0;
        end else begin
            r_sync_q     <= w_sync_d;
            r_pgt_prev_q <= w_pgt_prev_d;
        end
    end

    assign evt       = r_sync_q[SYNC_STAGES-1][5] & ~r_pgt_prev_q;
    assign evt_loadn = r_sync_q[SYNC_STAGES-1][4];
    assign evt_d     = r_sync_q[SYNC_STAGES-1][3:0];

endmodule
`default_nettype wire

// File: rtl/timer_entry.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_entry                                                          |
// | Keypad digit entry into an MM:SS BCD register and countdown control. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module timer_entry
    import timer_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int TICKS_PER_SEC = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       running,
    output logic       done
);

    localparam logic [7:0] c_presc_last = 8'(TICKS_PER_SEC - 1);

    logic       w_evt;
    logic [3:0] w_evt_d;
    logic       w_evt_loadn;

    pgt_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pgt_sync (
        .clk       (clk),
        .reset     (reset),
        .pgt       (pgt),
        .D         (D),
        .loadn     (loadn),
        .evt       (w_evt),
        .evt_d     (w_evt_d),
        .evt_loadn (w_evt_loadn)
    );

    state_t    r_state_q, w_state_d;
    bcd_time_t r_time_q,  w_time_d;
    logic [7:0] r_presc_q, w_presc_d;
    logic      r_start_q, r_stop_q;
    logic      r_running_q, r_done_q;

    logic      w_start_rise, w_stop_rise, w_digit, w_tick;
    bcd_time_t w_dec;

    always_comb begin
        w_start_rise = start & ~r_start_q;
        w_stop_rise  = stop & ~r_stop_q;
        w_digit      = w_evt & ~w_evt_loadn & (w_evt_d <= BCD_MAX_UNITS);
        w_tick       = w_evt & w_evt_loadn;
        w_dec        = bcd_dec(r_time_q);

        w_state_d = r_state_q;
        w_time_d  = r_time_q;
        w_presc_d = r_presc_q;

        if (clear) begin
            w_state_d = IDLE;
            w_time_d  = TIME_ZERO;
            w_presc_d = 8'd0;
        end else if (w_stop_rise) begin
            case (r_state_q)
                RUNNING: w_state_d = PAUSED;
                ENTRY, PAUSED, DONE: begin
                    w_state_d = IDLE;
                    w_time_d  = TIME_ZERO;
                    w_presc_d = 8'd0;
                end
                default: w_state_d = r_state_q;
            endcase
        end else if (w_start_rise) begin
            case (r_state_q)
                ENTRY: begin
                    if (r_time_q != TIME_ZERO) begin
                        w_state_d = RUNNING;
                        w_presc_d = 8'd0;
                    end
                end
                PAUSED: w_state_d = RUNNING;
                DONE: begin
                    w_state_d = IDLE;
                    w_time_d  = TIME_ZERO;
                end
                default: w_state_d = r_state_q;
            endcase
        end else begin
            case (r_state_q)
                IDLE, DONE: begin
                    if (w_digit) begin
                        w_state_d = ENTRY;
                        w_time_d  = {12'h000, w_evt_d};
                    end
                end
                ENTRY: begin
                    if (w_digit) begin
                        w_time_d = {r_time_q.min_units, r_time_q.sec_tens,
                                    r_time_q.sec_units, w_evt_d};
                    end
                end
                RUNNING: begin
                    if (w_tick) begin
                        if (r_presc_q >= c_presc_last) begin
                            w_presc_d = 8'd0;
                            w_time_d  = w_dec;
                            if (w_dec == TIME_ZERO) begin
                                w_state_d = DONE;
                            end
                        end else begin
                            w_presc_d = r_presc_q + 8'd1;
                        end
                    end
                end
                default: w_state_d = r_state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= IDLE;
            r_time_q    <= TIME_ZERO;
            r_presc_q   <= 8'd0;
            r_start_q   <= 1'b0;
            r_stop_q    <= 1'b0;
            r_running_q <= 1'b0;
            r_done_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_time_q    <= w_time_d;
            r_presc_q   <= w_presc_d;
            r_start_q   <= start;
            r_stop_q    <= stop;
            r_running_q <= (w_state_d == RUNNING);
            r_done_q    <= (w_state_d == DONE);
        end
    end

    assign min_tens  = r_time_q.min_tens;
    assign min_units = r_time_q.min_units;
    assign sec_tens  = r_time_q.sec_tens;
    assign sec_units = r_time_q.sec_units;
    assign running   = r_running_q;
    assign done      = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_entry.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_timer_entry                                                       |
// | Directed table-driven bench for timer_entry.                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_timer_entry;

    localparam int OP_KEY   = 0;
    localparam int OP_TICK  = 1;
    localparam int OP_START = 2;
    localparam int OP_STOP  = 3;
    localparam int OP_CLEAR = 4;

    typedef struct {
        int          op;
        logic [3:0]  dat;
        logic [15:0] t;
        logic        r;
        logic        dn;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, loadn, pgt, start, stop, clear;
    logic [3:0] D;
    logic [3:0] mt, mu, st, su;
    logic       running, done;

    int n_cmp  = 0;
    int n_fail = 0;
    vec_t vq[$];

    timer_entry #(
        .SYNC_STAGES   (2),
        .TICKS_PER_SEC (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .D         (D),
        .loadn     (loadn),
        .pgt       (pgt),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .min_tens  (mt),
        .min_units (mu),
        .sec_tens  (st),
        .sec_units (su),
        .running   (running),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] et, input logic er, input logic ed);
        n_cmp++;
        if ({mt, mu, st, su} !== et || running !== er || done !== ed) begin
            n_fail++;
            $display("FAIL %s: got time=%h run=%b done=%b, want time=%h run=%b done=%b",
                     name, {mt, mu, st, su}, running, done, et, er, ed);
        end
    endtask

    task automatic key(input logic [3:0] d);
        D = d; loadn = 1'b0; pgt = 1'b1;
        repeat (3) @(negedge clk);
        pgt = 1'b0; loadn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic tick();
        loadn = 1'b1; pgt = 1'b1;
        repeat (3) @(negedge clk);
        pgt = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse(input int op);
        case (op)
            OP_START: start = 1'b1;
            OP_STOP:  stop  = 1'b1;
            default:  clear = 1'b1;
        endcase
        @(negedge clk);
        start = 1'b0; stop = 1'b0; clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic add(input int op, input logic [3:0] dat, input logic [15:0] t,
                       input logic r, input logic dn);
        vq.push_back('{op, dat, t, r, dn});
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            case (vq[i].op)
                OP_KEY:  key(vq[i].dat);
                OP_TICK: tick();
                default: pulse(vq[i].op);
            endcase
            check($sformatf("%s[%0d]", tag, i), vq[i].t, vq[i].r, vq[i].dn);
        end
        vq.delete();
    endtask

    initial begin
        reset = 1'b1; loadn = 1'b1; pgt = 1'b0; D = 4'd0;
        start = 1'b0; stop = 1'b0; clear = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hold", 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", 16'h0000, 1'b0, 1'b0);

        // Digit latency: unchanged two cycles after the pgt rise, visible on the third.
        D = 4'd4; loadn = 1'b0; pgt = 1'b1;
        repeat (2) @(negedge clk);
        check("latency_2clk", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        check("latency_3clk", 16'h0004, 1'b0, 1'b0);
        pgt = 1'b0; loadn = 1'b1;
        repeat (3) @(negedge clk);
        pulse(OP_STOP);
        check("latency_stop", 16'h0000, 1'b0, 1'b0);

        add(OP_KEY, 4'd1, 16'h0001, 0, 0);
        add(OP_KEY, 4'd2, 16'h0012, 0, 0);
        add(OP_KEY, 4'd3, 16'h0123, 0, 0);
        add(OP_KEY, 4'd0, 16'h1230, 0, 0);
        add(OP_STOP, 4'd0, 16'h0000, 0, 0);
        add(OP_KEY, 4'd1, 16'h0001, 0, 0);
        add(OP_KEY, 4'd2, 16'h0012, 0, 0);
        add(OP_KEY, 4'd3, 16'h0123, 0, 0);
        add(OP_KEY, 4'd4, 16'h1234, 0, 0);
        add(OP_KEY, 4'd5, 16'h2345, 0, 0);
        add(OP_KEY, 4'hC, 16'h2345, 0, 0);
        add(OP_STOP, 4'd0, 16'h0000, 0, 0);
        add(OP_KEY, 4'd1, 16'h0001, 0, 0);
        add(OP_KEY, 4'd0, 16'h0010, 0, 0);
        add(OP_KEY, 4'd0, 16'h0100, 0, 0);
        add(OP_START, 4'd0, 16'h0100, 1, 0);
        add(OP_TICK, 4'd0, 16'h0059, 1, 0);
        add(OP_KEY, 4'd5, 16'h0059, 1, 0);
        run_table("entry");

        // Remaining 59 seconds down to DONE.
        for (int i = 1; i <= 59; i++) begin
            int secs;
            logic [3:0] tens, units;
            secs  = 59 - i;
            tens  = 4'(secs / 10);
            units = 4'(secs % 10);
            tick();
            check($sformatf("count_%0d", secs), {8'h00, tens, units},
                  (secs != 0), (secs == 0));
        end

        add(OP_KEY, 4'd7, 16'h0007, 0, 0);
        add(OP_STOP, 4'd0, 16'h0000, 0, 0);
        add(OP_KEY, 4'd1, 16'h0001, 0, 0);
        add(OP_KEY, 4'd1, 16'h0011, 0, 0);
        add(OP_START, 4'd0, 16'h0011, 1, 0);
        add(OP_TICK, 4'd0, 16'h0010, 1, 0);
        add(OP_STOP, 4'd0, 16'h0010, 0, 0);
        add(OP_TICK, 4'd0, 16'h0010, 0, 0);
        add(OP_TICK, 4'd0, 16'h0010, 0, 0);
        add(OP_TICK, 4'd0, 16'h0010, 0, 0);
        add(OP_KEY, 4'd3, 16'h0010, 0, 0);
        add(OP_START, 4'd0, 16'h0010, 1, 0);
        add(OP_TICK, 4'd0, 16'h0009, 1, 0);
        add(OP_STOP, 4'd0, 16'h0009, 0, 0);
        add(OP_STOP, 4'd0, 16'h0000, 0, 0);
        add(OP_START, 4'd0, 16'h0000, 0, 0);
        add(OP_KEY, 4'd9, 16'h0009, 0, 0);
        add(OP_KEY, 4'd9, 16'h0099, 0, 0);
        add(OP_START, 4'd0, 16'h0099, 1, 0);
        add(OP_TICK, 4'd0, 16'h0098, 1, 0);
        add(OP_STOP, 4'd0, 16'h0098, 0, 0);
        add(OP_STOP, 4'd0, 16'h0000, 0, 0);
        add(OP_KEY, 4'd1, 16'h0001, 0, 0);
        add(OP_KEY, 4'd0, 16'h0010, 0, 0);
        add(OP_KEY, 4'd0, 16'h0100, 0, 0);
        add(OP_KEY, 4'd0, 16'h1000, 0, 0);
        add(OP_START, 4'd0, 16'h1000, 1, 0);
        add(OP_TICK, 4'd0, 16'h0959, 1, 0);
        add(OP_CLEAR, 4'd0, 16'h0000, 0, 0);
        add(OP_START, 4'd0, 16'h0000, 0, 0);
        run_table("ctrl");

        // clear and start in the same cycle while in ENTRY.
        key(4'd4);
        check("pre_clear", 16'h0004, 1'b0, 1'b0);
        clear = 1'b1; start = 1'b1;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        @(negedge clk);
        check("clear_vs_start", 16'h0000, 1'b0, 1'b0);
        pulse(OP_START);
        check("start_after_clear", 16'h0000, 1'b0, 1'b0);

        // Held stop acts once; then reset mid-count.
        key(4'd5); key(4'd1); key(4'd8);
        pulse(OP_START);
        tick();
        check("run_0517", 16'h0517, 1'b1, 1'b0);
        stop = 1'b1;
        repeat (3) @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        check("held_stop", 16'h0517, 1'b0, 1'b0);
        pulse(OP_START);
        check("resume_0517", 16'h0517, 1'b1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("reset_midcount", 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        key(4'd2);
        check("after_reset_key", 16'h0002, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_entry.md
Name: timer_entry

Overview:
- Downstream consumer of the keypad encoder. Takes its D/loadn/pgt outputs and assembles keypad digits into a 4-digit BCD MM:SS time register.
- Runs the microwave countdown from that register, using the encoder's pgt divided-clock tick.
- Drives the display digits and the magnetron-on/done status.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on pgt, D and loadn (minimum 2).
- TICKS_PER_SEC, 1, number of qualified pgt ticks per one-second decrement (range 1..255).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- D  input  4  BCD digit from encoder.
- loadn  input  1  encoder key-valid, active-low (0 = key held).
- pgt  input  1  encoder strobe: debounced key pulse while keying, divided tick otherwise.
- start  input  1  level, active-high start request.
- stop  input  1  level, active-high pause/cancel request.
- clear  input  1  level, active-high clear request.
- min_tens, min_units, sec_tens, sec_units  output  4 each  BCD time register.
- running  output  1  high in RUNNING (magnetron on).
- done  output  1  high in DONE.

Behaviour:
- Synchronisation: pgt, D and loadn each pass through SYNC_STAGES flops.
  - A pgt event is a rising edge of the synchronised pgt, detected via one extra register.
  - D/loadn are sampled from the same synchronised stage, so they stay aligned with the edge.
  - Register outputs change 3 clk cycles after the input pgt rise (SYNC_STAGES=2).
- Event classes:
  - digit event: pgt event with synchronised loadn=0 and D<=9. D>9 is ignored.
  - tick event: pgt event with loadn=1.
- States:
  - IDLE: time=0000.
    - digit -> shift, go to ENTRY.
    - start ignored.
  - ENTRY:
    - digit -> shift left: min_tens<=min_units, min_units<=sec_tens, sec_tens<=sec_units, sec_units<=D. The oldest digit is lost on the 5th entry.
    - start with time!=0000 -> RUNNING, tick prescaler cleared.
    - stop -> IDLE, time=0000.
  - RUNNING:
    - digits ignored.
    - Each TICKS_PER_SEC tick events -> decrement time by 1 s.
    - Decrement reaching 0000 -> DONE on the same cycle.
    - stop -> PAUSED, prescaler held.
  - PAUSED:
    - start -> RUNNING, prescaler resumes from its held count.
    - stop -> IDLE, time=0000.
    - digits ignored.
  - DONE:
    - time holds 0000.
    - digit -> time=000D, go to ENTRY.
    - stop or start -> IDLE.
- BCD decrement:
  - sec_units borrows into sec_tens; sec 00 borrows a minute and becomes 59.
  - Entered seconds >59 (e.g. 0:99) are kept as entered and count down 99..00 before the minute borrow.
  - No normalisation.
- Priority when events coincide in one cycle: reset > clear > stop > start > digit/tick.
  - clear from any state -> IDLE, time=0000, prescaler=0.
- start and stop are level-sampled with internal edge detect: a held level acts once.
- Reset values:
  - state=IDLE, all four digits=0, running=0, done=0, prescaler=0.
  - All synchroniser/edge flops=0, so a high pgt at reset release is not an event.
- Reset mid-count aborts immediately; no partial state is kept.
- running and done are registered decodes of state (no glitches).

Decomposition:
- Package timer_pkg:
  - state enum: IDLE, ENTRY, RUNNING, PAUSED, DONE.
  - BCD_MAX_UNITS=9, SEC_TENS_WRAP=5, TIME_ZERO constant.
- Sub-module pgt_sync: SYNC_STAGES synchroniser for pgt/D/loadn plus rising-edge detector. Outputs evt, evt_d, evt_loadn.
- BCD decrement is a combinational function in the package.

Test Plan:
- Keys 1,2,3,0 (pgt pulses with loadn=0) -> display 12:30; each digit appears exactly 3 clk after its pgt rise.
- Keys 1,2,3,4,5 -> 23:45; D=4'hC pulse -> no change.
- 01:00, start, 1 tick (TICKS_PER_SEC=1) -> 00:59, running=1; 59 more ticks -> 00:00, done=1, running=0.
- RUNNING at 00:10, stop -> PAUSED, 3 ticks -> still 00:10; start -> resumes, next tick -> 00:09; stop, stop -> IDLE 00:00.
- start with 00:00 in IDLE -> stays IDLE; clear and start asserted the same cycle in ENTRY -> IDLE, 00:00.
- Reset asserted mid-count at 05:17 -> next cycle 00:00, IDLE, running=0. DONE followed by key 7 -> 00:07, ENTRY, done=0.
